// File: rtl/true_dpram_sclk_pkg.sv
// Shared sizing defaults and the output-select encoding for the true dual-port RAM.
// Each port's q comes from the array, a same-edge bypass, or a forced zero after reset.
package true_dpram_sclk_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ADDR_WIDTH_DEF = 6;
  localparam int unsigned DEPTH_DEF      = 2 ** ADDR_WIDTH_DEF;

  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_BYP  = 2'd2
  } q_sel_e;

endpackage : true_dpram_sclk_pkg

// File: rtl/true_dpram_sclk_port.sv
// One RAM port's output stage: 1-cycle registered read with write-first and cross-port bypass.
// No backpressure; a new access is accepted every cycle.
module true_dpram_sclk_port
  import true_dpram_sclk_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter bit          OWN_WINS   = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] wdat_i,
  input  logic                  x_vld_i,
  input  logic [DATA_WIDTH-1:0] x_dat_i,
  input  logic [DATA_WIDTH-1:0] ram_dat_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  q_sel_e                sel_d, sel_q;
  logic [DATA_WIDTH-1:0] byp_dat_d, byp_dat_q;

  // x_vld_i means the other port writes this port's address on this edge.
  // OWN_WINS decides whether our own write or the other port's write is returned.
  always_comb begin
    sel_d     = SEL_RAM;
    byp_dat_d = wdat_i;
    if (we_i && (OWN_WINS || !x_vld_i)) begin
      sel_d     = SEL_BYP;
      byp_dat_d = wdat_i;
    end else if (x_vld_i) begin
      sel_d     = SEL_BYP;
      byp_dat_d = x_dat_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sel_q     <= SEL_ZERO;
      byp_dat_q <= '0;
    end else begin
      sel_q     <= sel_d;
      byp_dat_q <= byp_dat_d;
    end
  end

  // Mux sits after the registers so the array read stays a clean synchronous BRAM output.
  always_comb begin
    q_o = '0;
    unique case (sel_q)
      SEL_ZERO: q_o = '0;
      SEL_RAM:  q_o = ram_dat_i;
      SEL_BYP:  q_o = byp_dat_q;
      default:  q_o = '0;
    endcase
  end

endmodule : true_dpram_sclk_port

// File: rtl/true_dpram_sclk.sv
// True dual-port single-clock RAM, 1-cycle read latency, fully defined same-address collisions.
// No backpressure; both ports accept an access every cycle; port A wins a write-write tie.
module true_dpram_sclk
  import true_dpram_sclk_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic                  we_a,
  output logic [DATA_WIDTH-1:0] q_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic                  we_b,
  output logic [DATA_WIDTH-1:0] q_b
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] ram_rd_a_q, ram_rd_b_q;
  logic                  addr_eq;
  logic                  wr_a, wr_b;

  assign addr_eq = (addr_a == addr_b);
  assign wr_a    = rst_n && we_a;
  // B's write is dropped when A writes the same word, so the array holds data_a.
  assign wr_b    = rst_n && we_b && !(we_a && addr_eq);

  // Array has no reset; its read registers may return stale data, the port stage masks that.
  always_ff @(posedge clk) begin
    if (wr_a) begin
      mem_q[addr_a] <= data_a;
    end
    if (wr_b) begin
      mem_q[addr_b] <= data_b;
    end
    ram_rd_a_q <= mem_q[addr_a];
    ram_rd_b_q <= mem_q[addr_b];
  end

  true_dpram_sclk_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .OWN_WINS   (1'b1)
  ) u_port_a (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .we_i      (we_a),
    .wdat_i    (data_a),
    .x_vld_i   (we_b && addr_eq),
    .x_dat_i   (data_b),
    .ram_dat_i (ram_rd_a_q),
    .q_o       (q_a)
  );

  true_dpram_sclk_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .OWN_WINS   (1'b0)
  ) u_port_b (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .we_i      (we_b),
    .wdat_i    (data_b),
    .x_vld_i   (we_a && addr_eq),
    .x_dat_i   (data_a),
    .ram_dat_i (ram_rd_b_q),
    .q_o       (q_b)
  );

endmodule : true_dpram_sclk

// File: tb/tb_true_dpram_sclk.sv
// Directed plus random-collision bench for true_dpram_sclk against a reference memory model.
// Expected q values are queued when a cycle is driven and popped after its rising edge.
module tb_true_dpram_sclk;

  localparam int DW = 8;
  localparam int AW = 6;
  localparam int DEPTH = 2 ** AW;

  typedef struct {
    bit          chk;
    logic [DW-1:0] val;
    string       tag;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] data_a = '0, data_b = '0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic          we_a = 1'b0, we_b = 1'b0;
  logic [DW-1:0] q_a, q_b;

  logic [DW-1:0] model_mem [DEPTH];
  bit            model_known [DEPTH];
  exp_t          exp_a_q[$];
  exp_t          exp_b_q[$];

  int errors = 0;
  int checks = 0;

  true_dpram_sclk #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_a (data_a),
    .addr_a (addr_a),
    .we_a   (we_a),
    .q_a    (q_a),
    .data_b (data_b),
    .addr_b (addr_b),
    .we_b   (we_b),
    .q_b    (q_b)
  );

  always #5 clk = ~clk;

  task automatic cyc(input bit r, input bit wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                     input bit wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                     input string tag);
    exp_t ea, eb, pa, pb;
    @(negedge clk);
    rst_n  = r;
    we_a   = wa; addr_a = aa; data_a = da;
    we_b   = wb; addr_b = ab; data_b = db;
    ea.tag = tag; eb.tag = tag;
    if (!r) begin
      ea.chk = 1'b1; ea.val = '0;
      eb.chk = 1'b1; eb.val = '0;
    end else begin
      if (wa) begin
        ea.chk = 1'b1; ea.val = da;
      end else if (wb && ab == aa) begin
        ea.chk = 1'b1; ea.val = db;
      end else begin
        ea.chk = model_known[aa]; ea.val = model_mem[aa];
      end
      if (wa && aa == ab) begin
        eb.chk = 1'b1; eb.val = da;
      end else if (wb) begin
        eb.chk = 1'b1; eb.val = db;
      end else begin
        eb.chk = model_known[ab]; eb.val = model_mem[ab];
      end
      if (wb) begin
        model_mem[ab] = db; model_known[ab] = 1'b1;
      end
      if (wa) begin
        model_mem[aa] = da; model_known[aa] = 1'b1;
      end
    end
    exp_a_q.push_back(ea);
    exp_b_q.push_back(eb);
    @(posedge clk);
    #1;
    pa = exp_a_q.pop_front();
    pb = exp_b_q.pop_front();
    if (pa.chk) begin
      checks++;
      assert (q_a === pa.val) else begin
        errors++;
        $error("FAIL %s q_a: got %h expected %h", pa.tag, q_a, pa.val);
      end
    end
    if (pb.chk) begin
      checks++;
      assert (q_b === pb.val) else begin
        errors++;
        $error("FAIL %s q_b: got %h expected %h", pb.tag, q_b, pb.val);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i]   = '0;
      model_known[i] = 1'b0;
    end

    cyc(1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 6'd0, 8'h00, "reset0");
    cyc(1'b0, 1'b0, 6'd1, 8'h00, 1'b0, 6'd2, 8'h00, "reset1");

    cyc(1'b1, 1'b1, 6'd4,  8'h44, 1'b0, 6'd4,  8'h00, "prewrite4_bypass");
    cyc(1'b1, 1'b1, 6'd0,  8'hAA, 1'b0, 6'd0,  8'h00, "wrA0_rdB0");
    cyc(1'b1, 1'b0, 6'd4,  8'h00, 1'b0, 6'd0,  8'h00, "reread0");
    cyc(1'b1, 1'b0, 6'd1,  8'h00, 1'b1, 6'd1,  8'hBB, "wrB1_rdA1");
    cyc(1'b1, 1'b0, 6'd0,  8'h00, 1'b0, 6'd1,  8'h00, "rdA0_rdB1");
    cyc(1'b1, 1'b1, 6'd2,  8'hCC, 1'b1, 6'd3,  8'hDD, "wr_diff");
    cyc(1'b1, 1'b0, 6'd2,  8'h00, 1'b0, 6'd3,  8'h00, "rd_diff");
    cyc(1'b1, 1'b1, 6'd5,  8'h11, 1'b1, 6'd5,  8'h22, "wr_same5");
    cyc(1'b1, 1'b0, 6'd5,  8'h00, 1'b0, 6'd5,  8'h00, "rd_same5");
    cyc(1'b1, 1'b1, 6'd63, 8'hFF, 1'b0, 6'd62, 8'h00, "wrA63_wf");
    cyc(1'b1, 1'b0, 6'd63, 8'h00, 1'b0, 6'd63, 8'h00, "rd63");
    cyc(1'b0, 1'b1, 6'd4,  8'h77, 1'b0, 6'd4,  8'h00, "reset_drop_wr");
    cyc(1'b1, 1'b0, 6'd4,  8'h00, 1'b0, 6'd63, 8'h00, "post_reset_rd");
    cyc(1'b1, 1'b0, 6'd63, 8'h00, 1'b0, 6'd4,  8'h00, "post_reset_rd2");

    // Narrow address range so same-address collisions of every kind occur often.
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 31) != 0),
          ($urandom_range(0, 1) == 1), AW'($urandom_range(0, 7)), DW'($urandom),
          ($urandom_range(0, 1) == 1), AW'($urandom_range(0, 7)), DW'($urandom),
          "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_true_dpram_sclk

// File: doc/true_dpram_sclk.md
# true_dpram_sclk

True dual-port synchronous RAM with one shared clock, used as a general-purpose on-chip buffer between two independent agents. Ports A and B can each read or write any location every cycle. Reads are registered with one-cycle latency. The behaviour of every same-address collision between the two ports is fully defined.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 6, address width; depth = 2**ADDR_WIDTH (64 words)

- clk  input  1  single clock; all activity on the rising edge
- rst_n  input  1  reset, synchronous and active-low
- data_a  input  DATA_WIDTH  port A write data
- addr_a  input  ADDR_WIDTH  port A address
- we_a  input  1  port A write enable
- q_a  output  DATA_WIDTH  port A registered read data
- data_b  input  DATA_WIDTH  port B write data
- addr_b  input  ADDR_WIDTH  port B address
- we_b  input  1  port B write enable
- q_b  output  DATA_WIDTH  port B registered read data

## Operation
- Each port performs one access per cycle:
  - write if its we is 1;
  - otherwise read.
- Write: at the rising edge, mem[addr] <= data.
- Same-port read during write is write-first: q of the writing port takes the newly written data.
- Read: at the rising edge, q <= mem[addr].
- Cross-port collision, one port writes and the other reads the same address in the same cycle:
  - the reading port's q returns the new write data (bypass);
  - the old contents are never returned.
- Both ports write the same address in the same cycle:
  - port A wins; memory holds data_a;
  - q_a and q_b both return data_a.
- Both ports write different addresses: both writes complete.
- All addresses 0..2**ADDR_WIDTH-1 are valid, including all-ones. There is no out-of-range case.
- Reset (rst_n=0 at a rising edge):
  - q_a and q_b clear to 0;
  - writes during that edge are suppressed;
  - memory contents are not cleared.
- Memory contents are undefined after power-up until written.

## Timing
- Read latency is 1 cycle: the address presented before edge N appears on q after edge N.
- Write data is visible to either port at the edge it is written, via write-first or bypass. It is visible from the array for any access at edge N+1 onward.
- q holds its value until the next rising edge. There is no output enable; q updates every cycle.
- Reset mid-operation:
  - q is 0 on the cycle after the reset edge;
  - a write coinciding with the reset edge is dropped;
  - previously stored data is retained.
- No handshake; the block accepts a new access every cycle on each port.

## Structure
- Shared package holds DATA_WIDTH and ADDR_WIDTH defaults and the depth constant.
- Natural split is one sub-module, dpram_port, per port, instantiated twice. Each handles registered read, write-first, and reset of q.
- The memory array and the collision/bypass muxing stay in the top level.
- The array must infer block RAM. The bypass muxes sit on the output path only.

## Test plan
- Write 0xAA at addr 0 on A while B reads addr 0 in the same cycle -> q_b=0xAA after that edge, then q_b=0xAA again on the next read.
- Write 0xBB at addr 1 on B while A reads addr 1 -> q_a=0xBB. Next cycle, A reads addr 0 -> q_a=0xAA.
- Concurrent writes, A: 0xCC@2 and B: 0xDD@3. Next cycle, A reads 2 and B reads 3 -> q_a=0xCC, q_b=0xDD.
- Both ports write addr 5, A: 0x11 and B: 0x22 -> q_a=q_b=0x11, and a later read of 5 returns 0x11.
- Write 0xFF at addr 63 on A -> q_a=0xFF (write-first). Read 63 from B next cycle -> q_b=0xFF.
- Assert rst_n=0 for one edge while A writes 0x77@4 -> q_a=q_b=0, addr 4 is unchanged, and addr 63 still reads 0xFF.
